uart_receiver: RTL

- 8N1 asynchronous serial receiver; counterpart to the UART transmit path.
- Contains its own bit-period counter, which re-phases on each start edge so sampling lands mid-bit.
- Delivers each received byte as a single-cycle VALID strobe to the CPU's memory-mapped UART peripheral logic.
- Flags stop-bit errors; suppresses false starts.

---
 rtl/uart_receiver.sv | 131 +++++++++++++
 1 files changed

// File: rtl/uart_receiver.sv
// 8N1 asynchronous serial receiver.
// A two-flop synchronizer feeds a five-state FSM (IDLE, START, DATA, STOP,
// WAIT_IDLE). A 16-bit bit-period counter is cleared on every state change,
// so sampling re-phases on each start edge and lands mid-bit. Each good byte
// appears on DATA with a one-cycle VALID. A low stop bit gives a one-cycle
// FRAME_ERR, after which the receiver waits for the line to return high.
//
// Output protocol: VALID and FRAME_ERR are single-cycle strobes with no
// back-pressure. The consumer must capture DATA in the cycle VALID is high.
// DATA keeps its value until the next good frame.
module uart_receiver #(
  parameter int CLK_FREQ = 100000000,
  parameter int BAUD     = 115200,
  parameter int REF      = CLK_FREQ / BAUD,
  parameter int H_REF    = REF / 2
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       RX,
  output logic [7:0] DATA,
  output logic       VALID,
  output logic       FRAME_ERR,
  output logic       BUSY
);

  localparam logic [15:0] REF_M1 = 16'(REF - 1);
  localparam logic [15:0] H_M1   = 16'(H_REF - 1);

  typedef enum logic [2:0] {
    S_IDLE  = 3'd0,
    S_START = 3'd1,
    S_DATA  = 3'd2,
    S_STOP  = 3'd3,
    S_WAIT  = 3'd4
  } state_t;

  state_t      state;
  logic        rx_m;
  logic        rx_s;
  logic [15:0] cnt;
  logic [2:0]  bit_idx;
  logic [7:0]  shift;

  // Two-flop synchronizer for the asynchronous line; both flops reset to idle-high.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      rx_m <= 1'b1;
      rx_s <= 1'b1;
    end else begin
      rx_m <= RX;
      rx_s <= rx_m;
    end
  end

  // Receive FSM with the bit-period counter and registered output strobes.
  always_ff @(posedge CLK) begin
    if (!RST) begin
      state     <= S_IDLE;
      cnt       <= 16'd0;
      bit_idx   <= 3'd0;
      shift     <= 8'h00;
      DATA      <= 8'h00;
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
    end else begin
      VALID     <= 1'b0;
      FRAME_ERR <= 1'b0;
      cnt       <= cnt + 16'd1;
      case (state)
        S_IDLE: begin
          if (!rx_s) begin
            state <= S_START;
            cnt   <= 16'd0;
          end
        end
        S_START: begin
          // Half a bit after the edge: a high line here means a glitch.
          if (cnt == H_M1) begin
            cnt <= 16'd0;
            if (rx_s) begin
              state <= S_IDLE;
            end else begin
              state   <= S_DATA;
              bit_idx <= 3'd0;
            end
          end
        end
        S_DATA: begin
          if (cnt == REF_M1) begin
            cnt            <= 16'd0;
            shift[bit_idx] <= rx_s;
            bit_idx        <= bit_idx + 3'd1;
            if (bit_idx == 3'd7) begin
              state <= S_STOP;
            end
          end
        end
        S_STOP: begin
          // Returning to IDLE mid-stop-bit lets the next start edge be caught
          // even when frames arrive back to back.
          if (cnt == REF_M1) begin
            cnt <= 16'd0;
            if (rx_s) begin
              DATA  <= shift;
              VALID <= 1'b1;
              state <= S_IDLE;
            end else begin
              FRAME_ERR <= 1'b1;
              state     <= S_WAIT;
            end
          end
        end
        S_WAIT: begin
          // A line held low (break) gives one FRAME_ERR and no false frames.
          if (rx_s) begin
            state <= S_IDLE;
            cnt   <= 16'd0;
          end
        end
        default: begin
          state <= S_IDLE;
          cnt   <= 16'd0;
        end
      endcase
    end
  end

  // BUSY is decoded directly from state.
  assign BUSY = (state != S_IDLE);

endmodule
